// File: rtl/fadd_sched.sv
// Round-robin scheduler sharing one fixed-latency FP adder among NREQ requesters.
// Operands are registered into the adder and a requester tag rides a matching pipeline.
module fadd_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_sub,
  input  logic [32*NREQ-1:0]         req_a,
  input  logic [32*NREQ-1:0]         req_b,
  output logic [NREQ-1:0]            req_ready,
  output logic                       fa_valid,
  output logic [31:0]                fa_a,
  output logic [31:0]                fa_b,
  input  logic [31:0]                fa_res,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [31:0]                rsp_data,
  output logic [$clog2(LAT+3)-1:0]   outstanding,
  output logic                       idle
);

  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int OW = $clog2(LAT+3);

  logic [TW-1:0]   ptr_q, ptr_d;
  logic [TW-1:0]   gnt_idx_s;
  logic            found_s;
  logic            xfer_s;
  logic [NREQ-1:0] gnt_s;

  logic            fa_valid_q, fa_valid_d;
  logic [31:0]     fa_a_q, fa_a_d;
  logic [31:0]     fa_b_q, fa_b_d;
  logic [TW-1:0]   fa_tag_q, fa_tag_d;

  logic [LAT-1:0]  pv_q, pv_d;
  logic [TW-1:0]   pt_q [LAT];
  logic [TW-1:0]   pt_d [LAT];

  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;

  // Rotating-priority search starting at ptr; first valid requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    found_s   = 1'b0;
    gnt_idx_s = '0;
    gnt_s     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!found_s && req_valid[idx]) begin
        found_s   = 1'b1;
        gnt_idx_s = TW'(idx);
      end else begin
        found_s   = found_s;
      end
    end
    if (en && !rst && found_s) begin
      gnt_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  assign xfer_s = |gnt_s;

  // Next-state for pointer, adder inputs and the tag that travels with them.
  always_comb begin
    ptr_d      = ptr_q;
    fa_valid_d = xfer_s;
    fa_a_d     = fa_a_q;
    fa_b_d     = fa_b_q;
    fa_tag_d   = fa_tag_q;
    if (xfer_s) begin
      if (gnt_idx_s == TW'(NREQ-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx_s + TW'(1);
      end
      fa_a_d   = req_a[32*gnt_idx_s +: 32];
      fa_b_d   = {req_b[32*gnt_idx_s+31] ^ req_sub[gnt_idx_s], req_b[32*gnt_idx_s +: 31]};
      fa_tag_d = gnt_idx_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Tag pipeline is fed from the issue register so its tail lines up with fa_res.
  always_comb begin
    pv_d[0] = fa_valid_q;
    pt_d[0] = fa_tag_q;
    for (int j = 1; j < LAT; j++) begin
      pv_d[j] = pv_q[j-1];
      pt_d[j] = pt_q[j-1];
    end
  end

  // Response capture and outstanding bookkeeping.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (pv_q[LAT-1]) begin
      rsp_valid_d[pt_q[LAT-1]] = 1'b1;
      rsp_data_d               = fa_res;
    end else begin
      rsp_data_d = rsp_data_q;
    end
    case ({xfer_s, |rsp_valid_q})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      fa_valid_q    <= 1'b0;
      fa_a_q        <= 32'h0000_0000;
      fa_b_q        <= 32'h0000_0000;
      fa_tag_q      <= '0;
      pv_q          <= '0;
      for (int j = 0; j < LAT; j++) pt_q[j] <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= 32'h0000_0000;
      outstanding_q <= '0;
    end else begin
      ptr_q         <= ptr_d;
      fa_valid_q    <= fa_valid_d;
      fa_a_q        <= fa_a_d;
      fa_b_q        <= fa_b_d;
      fa_tag_q      <= fa_tag_d;
      pv_q          <= pv_d;
      for (int j = 0; j < LAT; j++) pt_q[j] <= pt_d[j];
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign req_ready   = gnt_s;
  assign fa_valid    = fa_valid_q;
  assign fa_a        = fa_a_q;
  assign fa_b        = fa_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign outstanding = outstanding_q;
  assign idle        = (outstanding_q == '0);

endmodule

// File: tb/tb_fadd_sched.sv
// Directed bench for fadd_sched: models a LAT-deep adder with a lookup of known sums
// and checks grants, issue registers, responses and the outstanding count.
module tb_fadd_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int OW   = $clog2(LAT+3);

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_sub;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              fa_valid;
  logic [31:0]       fa_a;
  logic [31:0]       fa_b;
  logic [31:0]       fa_res;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_data;
  logic [OW-1:0]     outstanding;
  logic              idle;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [NREQ-1:0] exp_v [512];
  logic [31:0]     exp_d [512];
  logic [31:0]     op_a [NREQ];
  logic [31:0]     op_b [NREQ];
  logic            op_sub [NREQ];
  logic [31:0]     op_sum [NREQ];
  logic [31:0]     pipe_q [LAT];

  always #5 clk = ~clk;

  fadd_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_sub(req_sub), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .fa_valid(fa_valid), .fa_a(fa_a), .fa_b(fa_b), .fa_res(fa_res),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .outstanding(outstanding), .idle(idle)
  );

  // Adder stand-in: only the operand pairs used below have known sums.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F80_0000, 32'h4000_0000}: fp_add = 32'h4040_0000;
      {32'h4040_0000, 32'hBF80_0000}: fp_add = 32'h4000_0000;
      {32'h3F80_0000, 32'h3F80_0000}: fp_add = 32'h4000_0000;
      {32'h4000_0000, 32'h4000_0000}: fp_add = 32'h4080_0000;
      {32'h4080_0000, 32'hBF80_0000}: fp_add = 32'h4040_0000;
      default:                        fp_add = 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    pipe_q[0] <= fp_add(fa_a, fa_b);
    for (int j = 1; j < LAT; j++) pipe_q[j] <= pipe_q[j-1];
  end
  assign fa_res = pipe_q[LAT-1];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one cycle and compare any response scheduled for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_eq("rsp_v", 32'(rsp_valid), 32'(exp_v[cyc]));
    if (exp_v[cyc] != '0) check_eq("rsp_d", rsp_data, exp_d[cyc]);
  endtask

  task automatic sched(input int at, input int who, input logic [31:0] d);
    exp_v[at]      = '0;
    exp_v[at][who] = 1'b1;
    exp_d[at]      = d;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_valid[i]       = 1'b1;
    req_sub[i]         = s;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
  endtask

  task automatic set_op(input int i);
    set_req(i, op_a[i], op_b[i], op_sub[i]);
  endtask

  initial begin
    int last;
    for (int i = 0; i < 512; i++) begin exp_v[i] = '0; exp_d[i] = 32'h0; end
    op_a[0] = 32'h3F80_0000; op_b[0] = 32'h3F80_0000; op_sub[0] = 1'b0; op_sum[0] = 32'h4000_0000;
    op_a[1] = 32'h4000_0000; op_b[1] = 32'h4000_0000; op_sub[1] = 1'b0; op_sum[1] = 32'h4080_0000;
    op_a[2] = 32'h3F80_0000; op_b[2] = 32'h4000_0000; op_sub[2] = 1'b0; op_sum[2] = 32'h4040_0000;
    op_a[3] = 32'h4080_0000; op_b[3] = 32'h3F80_0000; op_sub[3] = 1'b1; op_sum[3] = 32'h4040_0000;

    rst = 1'b1; en = 1'b1;
    req_valid = '0; req_sub = '0; req_a = '0; req_b = '0;
    set_op(0);
    tick(); tick();
    // Reset state; a valid request during reset must not be granted.
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_fav", 32'(fa_valid), 32'h0);
    check_eq("rst_faa", fa_a, 32'h0);
    check_eq("rst_fab", fa_b, 32'h0);
    check_eq("rst_rspd", rsp_data, 32'h0);
    check_eq("rst_out", 32'(outstanding), 32'h0);
    check_eq("rst_idle", 32'(idle), 32'h1);
    rst = 1'b0; req_valid = '0;
    tick();

    // Single add 1.0 + 2.0.
    set_req(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    #1;
    check_eq("add_ready", 32'(req_ready), 32'h1);
    sched(cyc+5, 0, 32'h4040_0000);
    tick();
    req_valid = '0;
    check_eq("add_fav", 32'(fa_valid), 32'h1);
    check_eq("add_faa", fa_a, 32'h3F80_0000);
    check_eq("add_fab", fa_b, 32'h4000_0000);
    check_eq("add_out1", 32'(outstanding), 32'h1);
    tick(); tick(); tick(); tick();
    check_eq("add_out_rsp", 32'(outstanding), 32'h1);
    tick();
    check_eq("add_out0", 32'(outstanding), 32'h0);
    check_eq("add_idle", 32'(idle), 32'h1);

    // Subtract 3.0 - 1.0 from requester 2 (pointer sits at 1).
    set_req(2, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    #1;
    check_eq("sub_ready", 32'(req_ready), 32'h4);
    sched(cyc+5, 2, 32'h4000_0000);
    tick();
    req_valid = '0;
    check_eq("sub_fab", fa_b, 32'hBF80_0000);
    check_eq("sub_fav", 32'(fa_valid), 32'h1);
    tick();
    check_eq("sub_fav0", 32'(fa_valid), 32'h0);
    check_eq("sub_fab_hold", fa_b, 32'hBF80_0000);
    repeat (5) tick();
    check_eq("sub_idle", 32'(idle), 32'h1);

    rst = 1'b1; tick(); rst = 1'b0;

    // Round robin with all four requesters valid.
    for (int i = 0; i < NREQ; i++) set_op(i);
    #1;
    for (int k = 0; k < 8; k++) begin
      check_eq("rr_ready", 32'(req_ready), 32'(1 << (k % NREQ)));
      if (k >= 5) check_eq("rr_out", 32'(outstanding), 32'(LAT+2));
      sched(cyc+5, k % NREQ, op_sum[k % NREQ]);
      tick();
    end
    req_valid = '0;
    repeat (6) tick();
    check_eq("rr_drain", 32'(outstanding), 32'h0);

    // Back-to-back single requester: counter holds at LAT+2.
    set_op(1);
    #1;
    for (int k = 0; k < 10; k++) begin
      check_eq("b2b_ready", 32'(req_ready), 32'h2);
      if (k >= 5) check_eq("b2b_out", 32'(outstanding), 32'(LAT+2));
      sched(cyc+5, 1, op_sum[1]);
      tick();
    end
    req_valid = '0;
    repeat (6) tick();
    check_eq("b2b_idle", 32'(idle), 32'h1);

    // en drops after two grants; in-flight ops still return.
    set_op(3);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("en_ready", 32'(req_ready), 32'h8);
      sched(cyc+5, 3, op_sum[3]);
      tick();
    end
    last = cyc - 1;
    en = 1'b0;
    #1;
    check_eq("en_gated", 32'(req_ready), 32'h0);
    while (cyc < last + LAT + 3) begin
      if (cyc == last + LAT + 2) check_eq("en_busy", 32'(idle), 32'h0);
      tick();
      check_eq("en_gated", 32'(req_ready), 32'h0);
    end
    check_eq("en_idle", 32'(idle), 32'h1);
    req_valid = '0; en = 1'b1;
    tick();

    // Reset with three ops in flight: none of them may respond.
    for (int i = 0; i < NREQ; i++) set_op(i);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("rf_ready", 32'(req_ready), 32'(1 << k));
      tick();
    end
    rst = 1'b1;
    #1;
    check_eq("rf_ready_rst", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    check_eq("rf_out", 32'(outstanding), 32'h0);
    check_eq("rf_fav", 32'(fa_valid), 32'h0);
    check_eq("rf_idle", 32'(idle), 32'h1);
    #1;
    check_eq("rf_ptr", 32'(req_ready), 32'h1);
    sched(cyc+5, 0, op_sum[0]);
    tick();
    req_valid = '0;
    repeat (8) tick();
    check_eq("rf_final_idle", 32'(idle), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fadd_sched.md
Name: fadd_sched

Overview:
Round-robin scheduler that shares one fixed-latency, non-stallable single-precision FP adder datapath (compare/align/add/normalize) among NREQ requesters. Accepts operand pairs over per-requester valid/ready handshakes and optionally negates operand b for subtraction. Drives the adder inputs from registers and carries a requester tag alongside the adder pipeline. Returns each sum to its originating requester as a one-cycle response pulse.

Parameters:
NREQ, 4, number of requesters (2..8)
LAT, 3, adder latency in cycles from fa_valid/fa_a/fa_b to fa_res (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  issue enable; 0 = no new grants, in-flight ops drain
req_valid  in  NREQ  per-requester operand valid
req_sub  in  NREQ  per-requester op select: 1 = a-b, 0 = a+b
req_a  in  32*NREQ  operand a, requester i at bits [32i+31:32i]
req_b  in  32*NREQ  operand b, same packing
req_ready  out  NREQ  one-hot grant (combinational)
fa_valid  out  1  adder input valid (registered)
fa_a  out  32  adder operand a (registered)
fa_b  out  32  adder operand b, sign already flipped if sub (registered)
fa_res  in  32  adder result, valid LAT cycles after fa_valid
rsp_valid  out  NREQ  one-hot response pulse (registered)
rsp_data  out  32  result for asserted rsp_valid bit (registered)
outstanding  out  ceil(log2(LAT+3))  ops granted but not yet responded
idle  out  1  1 when outstanding==0

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: ptr=0, fa_valid=0, fa_a=fa_b=0, tag pipeline valids all 0, rsp_valid=0, rsp_data=0, outstanding=0, idle=1.
- Arbitration: when en=1 and rst=0, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NREQ. req_ready is one-hot on that i and zero otherwise.
- req_ready is all-zero when en=0, during rst, or when no requester is valid.
- req_ready never depends on rsp or adder state; the adder never stalls.
- Handshake: a transfer occurs when req_valid[i]&req_ready[i] in cycle T. On transfer, ptr <= (i+1) mod NREQ. With no transfer, ptr holds.
- Issue: at T+1, fa_valid=1, fa_a=req_a[i], fa_b={req_b[i][31]^req_sub[i], req_b[i][30:0]}. With no transfer, fa_valid=0 and fa_a/fa_b hold their previous values.
- Tag pipeline: a LAT-deep shift register of {valid, tag[ceil(log2 NREQ)-1:0]} advances every cycle, aligned so its output accompanies fa_res at T+1+LAT.
- Response: at T+2+LAT, rsp_valid[tag]=1 for exactly one cycle and rsp_data=fa_res sampled at T+1+LAT. Otherwise rsp_valid=0 and rsp_data holds.
- Latency: LAT+2 cycles from handshake to response. Throughput: one op per cycle.
- Response order equals grant order.
- Outstanding counter: +1 on transfer, -1 on response pulse, unchanged when both occur in the same cycle. Maximum value is LAT+2, so it never wraps.
- Fairness: with en=1 continuously, any requester holding req_valid high is granted within NREQ cycles.
- en falling mid-stream: ops already granted complete normally. en has no effect on the tag pipeline or responses.
- Reset mid-operation: all in-flight ops are discarded and no response is issued for them. The fa_res values that arrive afterwards are ignored because the tag valids are 0.
- Requester dropping req_valid without grant: legal, nothing is recorded. After a transfer, the requester may present the next op in the following cycle.
- The scheduler never inspects operand values. NaN, Inf, zero and denormal operands pass through unchanged; only the sign of b is modified when req_sub=1.

Test Plan:
- Single add: rst released, en=1, req0 a=0x3F800000 (1.0), b=0x40000000 (2.0), sub=0, LAT=3, adder modelled by bench -> req_ready=0001 same cycle, fa_b=0x40000000 at T+1, rsp_valid=0001 with rsp_data=0x40400000 (3.0) at T+5, outstanding 1 then 0.
- Subtract: req2 a=0x40400000, b=0x3F800000, sub=1 -> fa_b=0xBF800000, rsp_valid=0100 with rsp_data=0x40000000 (2.0).
- Round-robin: all 4 requesters valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_valid order matches; outstanding peaks at 5 (LAT+2) and returns to 0.
- Simultaneous inc/dec: back-to-back single-requester stream for 10 cycles -> outstanding stays at 5 in steady state; responses arrive one per cycle with correct data.
- en gating: en dropped after 2 grants while req_valid is held -> req_ready=0, the 2 responses still arrive, idle=1 at T+LAT+3 after the last grant.
- Reset mid-flight: 3 ops granted, rst asserted for 1 cycle at T+2 -> no rsp_valid for those ops; outstanding=0, ptr=0, fa_valid=0 the cycle after rst.
